// File: rtl/shared_gate_pkg.sv
// Shared definitions for the arbitrated bitwise gate unit:
// opcode values and FSM state encoding.
package shared_gate_pkg;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_NAND = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/shared_gate_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above
// the pointer, wrapping back to index 0.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     idx,
    output logic               any_req
);

    logic found;
    int   j;

    always_comb begin
        grant   = '0;
        idx     = '0;
        found   = 1'b0;
        j       = 0;
        any_req = |req;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/shared_gate_arbiter.sv
// One registered AND/OR/XOR/NAND unit shared by NUM_REQ requesters
// through a round-robin arbiter and an IDLE/EXEC/RESP handshake FSM.
module shared_gate_arbiter
    import shared_gate_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int IDW     = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] a_flat,
    input  logic [NUM_REQ*WIDTH-1:0] b_flat,
    input  logic [NUM_REQ*2-1:0]     op_flat,
    output logic [NUM_REQ-1:0]       gnt,
    output logic                     busy,
    output logic                     rsp_valid,
    output logic [IDW-1:0]           rsp_id,
    output logic [WIDTH-1:0]         rsp_data,
    input  logic                     rsp_ready
);

    state_t             state;
    logic [IDW-1:0]     ptr;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [1:0]         op_q;
    logic [NUM_REQ-1:0] win_gnt;
    logic [IDW-1:0]     win_idx;
    logic               any_req;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_arb (
        .req     (req),
        .ptr     (ptr),
        .grant   (win_gnt),
        .idx     (win_idx),
        .any_req (any_req)
    );

    function automatic logic [WIDTH-1:0] gate_eval(
        input logic [1:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH-1:0] r;
        unique case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NAND: r = ~(a & b);
            default: r = '0;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ptr       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            gnt       <= '0;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
        end else begin
            gnt <= '0;
            unique case (state)
                S_IDLE: begin
                    if (any_req) begin
                        a_q    <= a_flat[win_idx*WIDTH +: WIDTH];
                        b_q    <= b_flat[win_idx*WIDTH +: WIDTH];
                        op_q   <= op_flat[win_idx*2 +: 2];
                        gnt    <= win_gnt;
                        rsp_id <= win_idx;
                        busy   <= 1'b1;
                        state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    rsp_data  <= gate_eval(op_q, a_q, b_q);
                    rsp_valid <= 1'b1;
                    state     <= S_RESP;
                end
                S_RESP: begin
                    // pointer moves past the winner only once the result is taken
                    if (rsp_valid && rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        ptr       <= (rsp_id == IDW'(NUM_REQ - 1)) ?
                                     '0 : rsp_id + 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shared_gate_arbiter.sv
// Scoreboard bench for shared_gate_arbiter: directed vectors push
// expected responses, a negedge monitor pops and compares them.
module tb_shared_gate_arbiter;
    import shared_gate_pkg::*;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int IDW = 2;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] a_flat;
    logic [N*W-1:0] b_flat;
    logic [N*2-1:0] op_flat;
    logic [N-1:0]   gnt;
    logic           busy;
    logic           rsp_valid;
    logic [IDW-1:0] rsp_id;
    logic [W-1:0]   rsp_data;
    logic           rsp_ready;

    shared_gate_arbiter #(.NUM_REQ(N), .WIDTH(W), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .a_flat    (a_flat),
        .b_flat    (b_flat),
        .op_flat   (op_flat),
        .gnt       (gnt),
        .busy      (busy),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [IDW-1:0] exp_id[$];
    logic [W-1:0]   exp_data[$];
    int             gnt_idx_q[$];
    int             gnt_cyc_q[$];

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)",
                     name, got, want, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // monitor: grant log, latency, hold-stability, scoreboard pop
    logic           pv = 1'b0;
    logic           pr = 1'b0;
    logic [IDW-1:0] pid = '0;
    logic [W-1:0]   pdata = '0;
    int             last_gcyc = -10;

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (gnt != '0) begin
                chk("gnt_onehot", 32'($onehot(gnt)), 32'd1);
                for (int i = 0; i < N; i++)
                    if (gnt[i]) gnt_idx_q.push_back(i);
                gnt_cyc_q.push_back(cyc);
                last_gcyc = cyc;
            end
            if (rsp_valid && !pv)
                chk("latency", 32'(cyc - last_gcyc), 32'd1);
            if (rsp_valid && pv && !pr) begin
                chk("hold_id", 32'(rsp_id), 32'(pid));
                chk("hold_data", 32'(rsp_data), 32'(pdata));
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_id.size() == 0) begin
                    chk("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    chk("rsp_id", 32'(rsp_id), 32'(exp_id.pop_front()));
                    chk("rsp_data", 32'(rsp_data), 32'(exp_data.pop_front()));
                end
            end
        end
        pv    = rsp_valid;
        pr    = rsp_ready;
        pid   = rsp_id;
        pdata = rsp_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [1:0] op);
        a_flat[i*W +: W] = a;
        b_flat[i*W +: W] = b;
        op_flat[i*2 +: 2] = op;
    endtask

    task automatic expect_rsp(input int id, input logic [W-1:0] d);
        exp_id.push_back(IDW'(id));
        exp_data.push_back(d);
    endtask

    task automatic wait_gnt(input int i);
        bit seen = 1'b0;
        for (int t = 0; t < 30 && !seen; t++) begin
            @(negedge clk);
            if (gnt[i]) seen = 1'b1;
        end
        chk($sformatf("gnt%0d_seen", i), 32'(seen), 32'd1);
    endtask

    task automatic drain();
        for (int t = 0; t < 60 && exp_id.size() != 0; t++)
            @(negedge clk);
        @(negedge clk);
        chk("drain", 32'(exp_id.size()), 32'd0);
    endtask

    logic [1:0] ops [4];
    logic [7:0] res [4];
    int         rr_order [5];
    int         n;
    bit         seen;

    initial begin
        ops = '{OP_AND, OP_OR, OP_XOR, OP_NAND};
        res = '{8'h30, 8'hFC, 8'hCC, 8'hCF};
        rr_order = '{0, 1, 2, 3, 0};

        rst_n = 1'b0;
        req = '0;
        a_flat = '0;
        b_flat = '0;
        op_flat = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        rst_n = 1'b1;
        rsp_ready = 1'b1;

        // single requester, all four opcodes
        for (int k = 0; k < 4; k++) begin
            tick();
            set_op(0, 8'hF0, 8'h3C, ops[k]);
            expect_rsp(0, res[k]);
            req = 4'b0001;
            wait_gnt(0);
            tick();
            req = '0;
            @(negedge clk);
            chk("gnt_pulse", 32'(gnt), 32'd0);
            drain();
        end

        // reset while holding a response
        tick();
        rsp_ready = 1'b0;
        set_op(2, 8'hFF, 8'hFF, OP_AND);
        req = 4'b0100;
        wait_gnt(2);
        tick();
        req = '0;
        seen = 1'b0;
        for (int t = 0; t < 10 && !seen; t++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        chk("pre_rst_valid", 32'(seen), 32'd1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_id", 32'(rsp_id), 32'd0);
        chk("mid_rst_data", 32'(rsp_data), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_gnt", 32'(gnt), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            chk("idle_gnt", 32'(gnt), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
        end

        // round robin with all four requesting
        tick();
        gnt_idx_q.delete();
        gnt_cyc_q.delete();
        set_op(0, 8'h0F, 8'hFF, OP_AND);
        set_op(1, 8'h0F, 8'hF0, OP_OR);
        set_op(2, 8'hAA, 8'hFF, OP_XOR);
        set_op(3, 8'h12, 8'h34, OP_NAND);
        expect_rsp(0, 8'h0F);
        expect_rsp(1, 8'hFF);
        expect_rsp(2, 8'h55);
        expect_rsp(3, 8'hEF);
        expect_rsp(0, 8'h0F);
        req = 4'b1111;
        n = 0;
        for (int t = 0; t < 60 && n < 5; t++) begin
            @(negedge clk);
            if (gnt != '0) n++;
        end
        chk("rr_grants", 32'(n), 32'd5);
        tick();
        req = '0;
        drain();
        chk("rr_count", 32'(gnt_idx_q.size()), 32'd5);
        for (int k = 0; k < 5 && k < gnt_idx_q.size(); k++)
            chk($sformatf("rr_order%0d", k), 32'(gnt_idx_q[k]),
                32'(rr_order[k]));
        for (int k = 1; k < 5 && k < gnt_cyc_q.size(); k++)
            chk($sformatf("rr_period%0d", k),
                32'(gnt_cyc_q[k] - gnt_cyc_q[k-1]), 32'd3);

        // backpressure: pointer is 1, requester 0 wins then stalls
        tick();
        gnt_idx_q.delete();
        rsp_ready = 1'b0;
        set_op(0, 8'hC3, 8'h5A, OP_XOR);
        expect_rsp(0, 8'h99);
        expect_rsp(1, 8'hFF);
        req = 4'b0001;
        wait_gnt(0);
        tick();
        req = 4'b1110;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_busy", 32'(busy), 32'd1);
            chk("bp_gnt", 32'(gnt), 32'd0);
        end
        tick();
        rsp_ready = 1'b1;
        wait_gnt(1);
        tick();
        req = '0;
        drain();
        chk("bp_count", 32'(gnt_idx_q.size()), 32'd2);
        if (gnt_idx_q.size() >= 2)
            chk("bp_next", 32'(gnt_idx_q[1]), 32'd1);

        // skip over idle requesters; operands latched at grant
        tick();
        gnt_idx_q.delete();
        set_op(3, 8'h12, 8'h34, OP_NAND);
        set_op(0, 8'h0F, 8'hFF, OP_AND);
        expect_rsp(3, 8'hEF);
        expect_rsp(0, 8'h0F);
        req = 4'b1001;
        wait_gnt(3);
        tick();
        req[3] = 1'b0;
        set_op(3, 8'h00, 8'h00, OP_AND);
        wait_gnt(0);
        tick();
        req = '0;
        set_op(0, 8'h00, 8'h00, OP_OR);
        drain();
        chk("skip_count", 32'(gnt_idx_q.size()), 32'd2);
        if (gnt_idx_q.size() >= 2) begin
            chk("skip_first", 32'(gnt_idx_q[0]), 32'd3);
            chk("skip_second", 32'(gnt_idx_q[1]), 32'd0);
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
